token_pass_sequencer: RTL and testbench

//  Upstream of token_engine. Walks one layer's tile loop nest (n outer, oc middle, ic inner).
//  For each pass it drives the GLB base addresses, is_bias and real channel counts, pulses pass_start,
//  and waits for pass_done. Ipsum accumulates in place: the ipsum base equals the opsum base of the same (n,oc) tile.

---
 rtl/token_pass_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_token_pass_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/token_pass_sequencer.sv
// rtl/token_pass_sequencer.sv - walks one layer's n/oc/ic tile loop nest and issues token_engine passes
//
// Purpose: for every (n, oc, ic) tile of a layer, present GLB base addresses,
//   is_bias and real channel counts, pulse pass_start_o, then wait for
//   pass_done_i. ic is the innermost loop, n the outermost. Ipsum accumulates
//   in place, so ipsum_addr_o always equals opsum_addr_o.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   layer_start_i                 pulse in IDLE: latch descriptor, begin layer
//   num_{n,oc,ic}_tiles_i         tile counts (any zero -> empty layer)
//   ic_last_real_i/oc_last_real_i channel counts of the last IC/OC tile
//   *_base_i, *_tile_bytes_i      layer base addresses and per-tile strides
//   pass_done_i                   pass completion from token_engine (WAIT only)
//   pass_start_o                  1-cycle pulse per pass
//   weight/ifmap/bias/ipsum/opsum_addr_o, is_bias_o, ic_real_o, oc_real_o
//                                 per-pass parameters, stable START..NEXT
//   busy_o                        high outside IDLE
//   layer_done_o                  1-cycle pulse at layer end
module token_pass_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 8,
  parameter int TILE_CH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              layer_start_i,
  input  logic [CNT_W-1:0]  num_n_tiles_i,
  input  logic [CNT_W-1:0]  num_oc_tiles_i,
  input  logic [CNT_W-1:0]  num_ic_tiles_i,
  input  logic [7:0]        ic_last_real_i,
  input  logic [7:0]        oc_last_real_i,
  input  logic [ADDR_W-1:0] weight_base_i,
  input  logic [ADDR_W-1:0] ifmap_base_i,
  input  logic [ADDR_W-1:0] bias_base_i,
  input  logic [ADDR_W-1:0] opsum_base_i,
  input  logic [ADDR_W-1:0] w_tile_bytes_i,
  input  logic [ADDR_W-1:0] if_tile_bytes_i,
  input  logic [ADDR_W-1:0] b_tile_bytes_i,
  input  logic [ADDR_W-1:0] op_tile_bytes_i,
  input  logic              pass_done_i,
  output logic              pass_start_o,
  output logic [ADDR_W-1:0] weight_addr_o,
  output logic [ADDR_W-1:0] ifmap_addr_o,
  output logic [ADDR_W-1:0] bias_addr_o,
  output logic [ADDR_W-1:0] ipsum_addr_o,
  output logic [ADDR_W-1:0] opsum_addr_o,
  output logic              is_bias_o,
  output logic [7:0]        ic_real_o,
  output logic [7:0]        oc_real_o,
  output logic              busy_o,
  output logic              layer_done_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [7:0]       FULL_CH = 8'(TILE_CH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0] state;

  // Latched layer descriptor
  logic [CNT_W-1:0]  num_n, num_oc, num_ic;
  logic [7:0]        ic_last_real, oc_last_real;
  logic [ADDR_W-1:0] weight_base, ifmap_base, bias_base, opsum_base;
  logic [ADDR_W-1:0] w_stride, if_stride, b_stride, op_stride;

  // Loop indices and address accumulators
  logic [CNT_W-1:0]  n_idx, oc_idx, ic_idx;
  logic [ADDR_W-1:0] w_acc, if_acc, if_row, b_acc, op_acc;
  logic              is_bias_q;
  logic [7:0]        ic_real_q, oc_real_q;

  logic              ic_at_last, oc_at_last, n_at_last, any_zero;
  logic [CNT_W-1:0]  ic_nxt, oc_nxt;

  always_comb begin
    ic_at_last = (ic_idx == num_ic - CNT_ONE);
    oc_at_last = (oc_idx == num_oc - CNT_ONE);
    n_at_last  = (n_idx  == num_n  - CNT_ONE);
    ic_nxt     = ic_at_last ? '0 : ic_idx + CNT_ONE;
    oc_nxt     = !ic_at_last ? oc_idx : (oc_at_last ? '0 : oc_idx + CNT_ONE);
    any_zero   = (num_n == '0) || (num_oc == '0) || (num_ic == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      num_n        <= '0;
      num_oc       <= '0;
      num_ic       <= '0;
      ic_last_real <= '0;
      oc_last_real <= '0;
      weight_base  <= '0;
      ifmap_base   <= '0;
      bias_base    <= '0;
      opsum_base   <= '0;
      w_stride     <= '0;
      if_stride    <= '0;
      b_stride     <= '0;
      op_stride    <= '0;
      n_idx        <= '0;
      oc_idx       <= '0;
      ic_idx       <= '0;
      w_acc        <= '0;
      if_acc       <= '0;
      if_row       <= '0;
      b_acc        <= '0;
      op_acc       <= '0;
      is_bias_q    <= 1'b0;
      ic_real_q    <= '0;
      oc_real_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (layer_start_i) begin
            num_n        <= num_n_tiles_i;
            num_oc       <= num_oc_tiles_i;
            num_ic       <= num_ic_tiles_i;
            ic_last_real <= ic_last_real_i;
            oc_last_real <= oc_last_real_i;
            weight_base  <= weight_base_i;
            ifmap_base   <= ifmap_base_i;
            bias_base    <= bias_base_i;
            opsum_base   <= opsum_base_i;
            w_stride     <= w_tile_bytes_i;
            if_stride    <= if_tile_bytes_i;
            b_stride     <= b_tile_bytes_i;
            op_stride    <= op_tile_bytes_i;
            state        <= S_LOAD;
          end
        end
        S_LOAD: begin
          n_idx     <= '0;
          oc_idx    <= '0;
          ic_idx    <= '0;
          w_acc     <= weight_base;
          if_acc    <= ifmap_base;
          if_row    <= ifmap_base;
          b_acc     <= bias_base;
          op_acc    <= opsum_base;
          is_bias_q <= 1'b1;
          ic_real_q <= (num_ic == CNT_ONE) ? ic_last_real : FULL_CH;
          oc_real_q <= (num_oc == CNT_ONE) ? oc_last_real : FULL_CH;
          state     <= any_zero ? S_DONE : S_START;
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (pass_done_i) state <= S_NEXT;
        end
        S_NEXT: begin
          if (ic_at_last && oc_at_last && n_at_last) begin
            state <= S_DONE;
          end else begin
            state     <= S_START;
            ic_idx    <= ic_nxt;
            oc_idx    <= oc_nxt;
            is_bias_q <= ic_at_last;
            ic_real_q <= (ic_nxt == num_ic - CNT_ONE) ? ic_last_real : FULL_CH;
            oc_real_q <= (oc_nxt == num_oc - CNT_ONE) ? oc_last_real : FULL_CH;
            if (!ic_at_last) begin
              w_acc  <= w_acc + w_stride;
              if_acc <= if_acc + if_stride;
            end else begin
              // opsum index n*num_oc+oc advances by one on every ic wrap
              op_acc <= op_acc + op_stride;
              if (!oc_at_last) begin
                // weight index oc*num_ic+ic keeps counting; ifmap rewinds to the row of this n
                w_acc  <= w_acc + w_stride;
                if_acc <= if_row;
                b_acc  <= b_acc + b_stride;
              end else begin
                // new n: ic was at its last value, so the next ifmap row starts one stride on
                n_idx  <= n_idx + CNT_ONE;
                w_acc  <= weight_base;
                if_acc <= if_acc + if_stride;
                if_row <= if_acc + if_stride;
                b_acc  <= bias_base;
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pass_start_o  = (state == S_START);
  assign layer_done_o  = (state == S_DONE);
  assign busy_o        = (state != S_IDLE);
  assign weight_addr_o = w_acc;
  assign ifmap_addr_o  = if_acc;
  assign bias_addr_o   = b_acc;
  assign opsum_addr_o  = op_acc;
  assign ipsum_addr_o  = op_acc;
  assign is_bias_o     = is_bias_q;
  assign ic_real_o     = ic_real_q;
  assign oc_real_o     = oc_real_q;

endmodule

// File: tb/tb_token_pass_sequencer.sv
// tb/tb_token_pass_sequencer.sv - self-checking bench for token_pass_sequencer
module tb_token_pass_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        layer_start_i = 1'b0;
  logic [7:0]  num_n_tiles_i = '0, num_oc_tiles_i = '0, num_ic_tiles_i = '0;
  logic [7:0]  ic_last_real_i = '0, oc_last_real_i = '0;
  logic [31:0] weight_base_i = '0, ifmap_base_i = '0, bias_base_i = '0, opsum_base_i = '0;
  logic [31:0] w_tile_bytes_i = '0, if_tile_bytes_i = '0, b_tile_bytes_i = '0, op_tile_bytes_i = '0;
  logic        pass_done_i = 1'b0;
  logic        pass_start_o, is_bias_o, busy_o, layer_done_o;
  logic [31:0] weight_addr_o, ifmap_addr_o, bias_addr_o, ipsum_addr_o, opsum_addr_o;
  logic [7:0]  ic_real_o, oc_real_o;

  token_pass_sequencer dut (
    .clk(clk), .rst(rst), .layer_start_i(layer_start_i),
    .num_n_tiles_i(num_n_tiles_i), .num_oc_tiles_i(num_oc_tiles_i), .num_ic_tiles_i(num_ic_tiles_i),
    .ic_last_real_i(ic_last_real_i), .oc_last_real_i(oc_last_real_i),
    .weight_base_i(weight_base_i), .ifmap_base_i(ifmap_base_i),
    .bias_base_i(bias_base_i), .opsum_base_i(opsum_base_i),
    .w_tile_bytes_i(w_tile_bytes_i), .if_tile_bytes_i(if_tile_bytes_i),
    .b_tile_bytes_i(b_tile_bytes_i), .op_tile_bytes_i(op_tile_bytes_i),
    .pass_done_i(pass_done_i), .pass_start_o(pass_start_o),
    .weight_addr_o(weight_addr_o), .ifmap_addr_o(ifmap_addr_o), .bias_addr_o(bias_addr_o),
    .ipsum_addr_o(ipsum_addr_o), .opsum_addr_o(opsum_addr_o), .is_bias_o(is_bias_o),
    .ic_real_o(ic_real_o), .oc_real_o(oc_real_o), .busy_o(busy_o), .layer_done_o(layer_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n, oc, ic;
    logic [7:0]  icl, ocl;
    logic [31:0] wb, ib, bb, ob, ws, is, bs, os;
    int          exp_passes;
  } desc_t;

  typedef struct {
    logic [31:0] w, i, b, ip, op;
    logic        bias;
    logic [7:0]  icr, ocr;
  } pass_t;

  int    checks = 0;
  int    errors = 0;
  pass_t got[$];
  int    npass, lat_first, lat_done, stab_bad, pass_lat_bad;
  bit    timed_out, idle_after;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic desc_t mk(input int n, oc, ic, input logic [7:0] icl, ocl,
                               input logic [31:0] wb, ib, bb, ob, ws, is, bs, os, input int ep);
    desc_t d;
    d.n = n; d.oc = oc; d.ic = ic; d.icl = icl; d.ocl = ocl;
    d.wb = wb; d.ib = ib; d.bb = bb; d.ob = ob;
    d.ws = ws; d.is = is; d.bs = bs; d.os = os;
    d.exp_passes = ep;
    return d;
  endfunction

  task automatic drive_desc(input desc_t d);
    num_n_tiles_i   = 8'(d.n);
    num_oc_tiles_i  = 8'(d.oc);
    num_ic_tiles_i  = 8'(d.ic);
    ic_last_real_i  = d.icl;
    oc_last_real_i  = d.ocl;
    weight_base_i   = d.wb;
    ifmap_base_i    = d.ib;
    bias_base_i     = d.bb;
    opsum_base_i    = d.ob;
    w_tile_bytes_i  = d.ws;
    if_tile_bytes_i = d.is;
    b_tile_bytes_i  = d.bs;
    op_tile_bytes_i = d.os;
  endtask

  task automatic scramble_desc();
    num_n_tiles_i  = 8'd7;
    num_oc_tiles_i = 8'd5;
    num_ic_tiles_i = 8'd6;
    ic_last_real_i = 8'd3;
    oc_last_real_i = 8'd9;
    weight_base_i  = ~weight_base_i;
    ifmap_base_i   = ~ifmap_base_i;
    bias_base_i    = ~bias_base_i;
    opsum_base_i   = ~opsum_base_i;
    w_tile_bytes_i = w_tile_bytes_i + 32'h11;
    if_tile_bytes_i = if_tile_bytes_i + 32'h22;
  endtask

  function automatic pass_t capture();
    pass_t p;
    p.w = weight_addr_o; p.i = ifmap_addr_o; p.b = bias_addr_o;
    p.ip = ipsum_addr_o; p.op = opsum_addr_o; p.bias = is_bias_o;
    p.icr = ic_real_o; p.ocr = oc_real_o;
    return p;
  endfunction

  function automatic bit same(input pass_t p);
    pass_t q;
    q = capture();
    return (q.w == p.w) && (q.i == p.i) && (q.b == p.b) && (q.ip == p.ip) &&
           (q.op == p.op) && (q.bias == p.bias) && (q.icr == p.icr) && (q.ocr == p.ocr);
  endfunction

  // Runs one layer as token_engine would: pass_done arrives dly+1 cycles after
  // each pass_start. With glitch set, pass_done is also pulsed in START and NEXT,
  // and layer_start is pulsed with a different descriptor during WAIT.
  task automatic run_layer(input desc_t d, input int dly, input bit glitch);
    int    c, pd_c;
    bit    done;
    pass_t p;
    got.delete();
    npass = 0; lat_first = -1; lat_done = -1; stab_bad = 0; pass_lat_bad = 0;
    timed_out = 0; pd_c = 0; done = 0;
    drive_desc(d);
    layer_start_i = 1'b1;
    tick();
    layer_start_i = 1'b0;
    c = 1;
    while (!done && !timed_out) begin
      pass_done_i = 1'b0;
      if (c > 4000) begin
        timed_out = 1;
      end else if (pass_start_o) begin
        p = capture();
        got.push_back(p);
        if (npass == 0) lat_first = c;
        else if (c - pd_c != 2) pass_lat_bad++;
        npass++;
        pass_done_i = glitch;
        tick(); c++;
        for (int k = 0; k < dly; k++) begin
          pass_done_i = 1'b0;
          if (glitch && k == 0) begin
            layer_start_i = 1'b1;
            scramble_desc();
          end else begin
            layer_start_i = 1'b0;
          end
          if (!same(p) || pass_start_o || layer_done_o) stab_bad++;
          tick(); c++;
        end
        layer_start_i = 1'b0;
        if (!same(p)) stab_bad++;
        pass_done_i = 1'b1;
        pd_c = c;
        tick(); c++;
        if (!same(p)) stab_bad++;
        pass_done_i = glitch;
      end else if (layer_done_o) begin
        done = 1;
        lat_done = (npass == 0) ? c : c - pd_c;
      end
      if (!done && !timed_out) begin
        tick(); c++;
      end
    end
    pass_done_i = 1'b0;
    tick();
    idle_after = !busy_o && !layer_done_o && !pass_start_o;
  endtask

  // Reference: the loop nest written directly, addresses by multiplication.
  task automatic check_model(input desc_t d, input string tag);
    int          k;
    logic [31:0] ew, ei, eb, eo;
    logic [7:0]  eic, eoc;
    k = 0;
    chk($sformatf("%s timeout", tag), timed_out, 0);
    chk($sformatf("%s pass count vs model", tag), npass, d.n * d.oc * d.ic);
    for (int n = 0; n < d.n; n++)
      for (int oc = 0; oc < d.oc; oc++)
        for (int ic = 0; ic < d.ic; ic++) begin
          ew  = d.wb + 32'(oc * d.ic + ic) * d.ws;
          ei  = d.ib + 32'(n * d.ic + ic) * d.is;
          eb  = d.bb + 32'(oc) * d.bs;
          eo  = d.ob + 32'(n * d.oc + oc) * d.os;
          eic = (ic == d.ic - 1) ? d.icl : 8'd32;
          eoc = (oc == d.oc - 1) ? d.ocl : 8'd32;
          if (k < got.size()) begin
            chk($sformatf("%s p%0d weight", tag, k), got[k].w, ew);
            chk($sformatf("%s p%0d ifmap", tag, k), got[k].i, ei);
            chk($sformatf("%s p%0d bias", tag, k), got[k].b, eb);
            chk($sformatf("%s p%0d opsum", tag, k), got[k].op, eo);
            chk($sformatf("%s p%0d ipsum", tag, k), got[k].ip, eo);
            chk($sformatf("%s p%0d is_bias", tag, k), got[k].bias, (ic == 0));
            chk($sformatf("%s p%0d ic_real", tag, k), got[k].icr, eic);
            chk($sformatf("%s p%0d oc_real", tag, k), got[k].ocr, eoc);
          end
          k++;
        end
    if (npass > 0) chk($sformatf("%s first pass latency", tag), lat_first, 2);
    chk($sformatf("%s layer_done latency", tag), lat_done, 2);
    chk($sformatf("%s pass_done->pass_start latency", tag), pass_lat_bad, 0);
    chk($sformatf("%s outputs stable", tag), stab_bad, 0);
    chk($sformatf("%s idle after done", tag), idle_after, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk($sformatf("%s pass_start", tag), pass_start_o, 0);
    chk($sformatf("%s layer_done", tag), layer_done_o, 0);
    chk($sformatf("%s busy", tag), busy_o, 0);
    chk($sformatf("%s weight", tag), weight_addr_o, 0);
    chk($sformatf("%s ifmap", tag), ifmap_addr_o, 0);
    chk($sformatf("%s bias", tag), bias_addr_o, 0);
    chk($sformatf("%s ipsum", tag), ipsum_addr_o, 0);
    chk($sformatf("%s opsum", tag), opsum_addr_o, 0);
    chk($sformatf("%s is_bias", tag), is_bias_o, 0);
    chk($sformatf("%s ic_real", tag), ic_real_o, 0);
    chk($sformatf("%s oc_real", tag), oc_real_o, 0);
  endtask

  desc_t tab[8];
  desc_t t2, rd;

  initial begin
    int cnt, c;
    tab[0] = mk(1, 1, 1, 8'd32, 8'd32, 32'h1000, 32'h2000, 32'h3000, 32'h4000,
                32'h10, 32'h20, 32'h30, 32'h40, 1);
    tab[1] = mk(2, 2, 3, 8'd32, 8'd32, 32'h10000, 32'h20000, 32'h30000, 32'h40000,
                32'h100, 32'h40, 32'h20, 32'h400, 12);
    tab[2] = mk(1, 2, 3, 8'd5, 8'd17, 32'h0, 32'h800, 32'h900, 32'hA00,
                32'h8, 32'h4, 32'h2, 32'h1, 6);
    tab[3] = mk(1, 0, 2, 8'd1, 8'd1, 32'h55, 32'h66, 32'h77, 32'h88,
                32'h1, 32'h1, 32'h1, 32'h1, 0);
    tab[4] = mk(0, 2, 2, 8'd1, 8'd1, 32'h1, 32'h2, 32'h3, 32'h4,
                32'h1, 32'h1, 32'h1, 32'h1, 0);
    tab[5] = mk(3, 1, 1, 8'd7, 8'd9, 32'hFFFF_FF00, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_0000,
                32'h80, 32'h10, 32'h4, 32'h8000, 3);
    tab[6] = mk(2, 3, 1, 8'd2, 8'd31, 32'hA0, 32'hB0, 32'hC0, 32'hD0,
                32'h1000, 32'h200, 32'h30, 32'h4, 6);
    tab[7] = mk(1, 1, 4, 8'd32, 8'd1, 32'h0, 32'h0, 32'h0, 32'h0,
                32'hFFFF_FFFF, 32'h3, 32'h5, 32'h7, 4);
    t2 = tab[1];

    // Reset state
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("idle");

    // Table vectors; T1 uses pass_done 5 cycles after pass_start
    for (int i = 0; i < 8; i++) begin
      run_layer(tab[i], (i == 0) ? 4 : 1 + (i % 3), 1'b0);
      chk($sformatf("tab%0d passes", i), npass, tab[i].exp_passes);
      check_model(tab[i], $sformatf("tab%0d", i));
    end

    // T2 spot check of pass (n1,oc1,ic2)
    run_layer(t2, 2, 1'b0);
    if (got.size() == 12) begin
      chk("T2 n1oc1ic2 weight", got[11].w, t2.wb + 32'h500);
      chk("T2 n1oc1ic2 ifmap", got[11].i, t2.ib + 32'h140);
      chk("T2 n1oc1ic2 bias", got[11].b, t2.bb + 32'h20);
      chk("T2 n1oc1ic2 opsum", got[11].op, t2.ob + 32'hC00);
    end else begin
      chk("T2 pass count", got.size(), 12);
    end

    // T5: ignored layer_start/pass_done pulses, descriptor changes mid-layer
    run_layer(t2, 3, 1'b1);
    chk("T5 passes", npass, 12);
    check_model(t2, "T5");
    run_layer(tab[2], 2, 1'b1);
    check_model(tab[2], "T5b");

    // T6: reset during WAIT of pass 4
    drive_desc(t2);
    layer_start_i = 1'b1;
    tick();
    layer_start_i = 1'b0;
    cnt = 0;
    c = 0;
    while (cnt < 4 && c < 2000) begin
      if (pass_start_o) begin
        cnt++;
        if (cnt < 4) begin
          tick(); c++;
          pass_done_i = 1'b1;
          tick(); c++;
          pass_done_i = 1'b0;
        end
      end
      if (cnt < 4) begin
        tick(); c++;
      end
    end
    chk("T6 reached pass 4", cnt, 4);
    tick();
    tick();
    chk("T6 busy in wait", busy_o, 1);
    rst = 1'b1;
    tick();
    check_all_zero("T6 after rst");
    rst = 1'b0;
    tick();
    check_all_zero("T6 idle");
    run_layer(t2, 1, 1'b0);
    check_model(t2, "T6 restart");

    // Randomized layers against the loop-nest model
    for (int r = 0; r < 12; r++) begin
      rd = mk($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 4),
              8'($urandom_range(1, 32)), 8'($urandom_range(1, 32)),
              $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom, 0);
      run_layer(rd, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      check_model(rd, $sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
